// File: rtl/md5_lane_scheduler.sv
// md5_lane_scheduler
// Shares one pancham MD5 core between NUM_LANES brute-force candidate
// generators. Lanes are granted round-robin. Only one job is outstanding at
// a time. Each digest is compared against the target latched on start.
// Optional watchdog on the WAIT state: define MD5_WDOG_EN. This adds the
// WDOG_CYCLES parameter and the wdog_err port.
module md5_lane_scheduler #(
    parameter int NUM_LANES   = 4,
    parameter int WORD_W      = 128,
`ifdef MD5_WDOG_EN
    parameter int MSG_WIDTH   = 128,
    parameter int WDOG_CYCLES = 255
`else
    parameter int MSG_WIDTH   = 128
`endif
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [127:0]                   target_hash,
    input  logic [NUM_LANES-1:0]           lane_valid,
    input  logic [NUM_LANES*WORD_W-1:0]    lane_word,
    output logic [NUM_LANES-1:0]           lane_ack,
    input  logic                           core_ready,
    output logic [WORD_W-1:0]              core_msg,
    output logic [7:0]                     core_msg_width,
    output logic                           core_msg_valid,
    input  logic                           core_out_valid,
    input  logic [127:0]                   core_digest,
    output logic                           busy,
    output logic                           found,
    output logic [$clog2(NUM_LANES)-1:0]   found_lane,
    output logic [WORD_W-1:0]              found_plaintext,
    output logic [127:0]                   last_digest,
`ifdef MD5_WDOG_EN
    output logic [31:0]                    hash_count,
    output logic                           wdog_err
`else
    output logic [31:0]                    hash_count
`endif
);

    localparam int                LANE_W    = $clog2(NUM_LANES);
    localparam logic [LANE_W:0]   LANES_EXT = (LANE_W + 1)'(NUM_LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [31:0]       HASH_MAX  = 32'hFFFF_FFFF;
`ifdef MD5_WDOG_EN
    localparam logic [31:0]       WDOG_LAST = 32'(WDOG_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Saturating increment for the digest counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        logic [31:0] result;
        if (value == HASH_MAX) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

    state_t                  state_r;
    logic [LANE_W-1:0]       ptr_r;
    logic [127:0]            target_r;
    logic [WORD_W-1:0]       job_word_r;
    logic [LANE_W-1:0]       job_lane_r;
    logic [NUM_LANES-1:0]    lane_ack_r;
    logic                    core_msg_valid_r;
    logic                    busy_r;
    logic                    found_r;
    logic [LANE_W-1:0]       found_lane_r;
    logic [WORD_W-1:0]       found_plaintext_r;
    logic [127:0]            last_digest_r;
    logic [31:0]             hash_count_r;
`ifdef MD5_WDOG_EN
    logic [31:0]             wdog_cnt_r;
    logic                    wdog_err_r;
`endif

    logic [2*NUM_LANES-1:0]  rot_s;
    logic                    arb_hit_s;
    logic [LANE_W-1:0]       arb_off_s;
    logic [LANE_W:0]         arb_sum_s;
    logic [LANE_W-1:0]       arb_idx_s;
    logic [LANE_W-1:0]       arb_next_s;
    logic [NUM_LANES-1:0]    arb_ack_s;
    logic [WORD_W-1:0]       arb_word_s;

    // Round-robin search: rotate the request vector so the pointer lane sits at bit 0.
    always_comb begin
        rot_s     = {lane_valid, lane_valid} >> ptr_r;
        arb_hit_s = 1'b0;
        arb_off_s = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!arb_hit_s && rot_s[k]) begin
                arb_hit_s = 1'b1;
                arb_off_s = LANE_W'(k);
            end else begin
                arb_off_s = arb_off_s;
            end
        end
    end

    // Map the rotated offset back to an absolute lane and compute the next pointer.
    always_comb begin
        arb_sum_s = {1'b0, ptr_r} + {1'b0, arb_off_s};
        if (arb_sum_s >= LANES_EXT) begin
            arb_sum_s = arb_sum_s - LANES_EXT;
        end else begin
            arb_sum_s = arb_sum_s;
        end
        arb_idx_s = arb_sum_s[LANE_W-1:0];
        if (arb_idx_s == LAST_LANE) begin
            arb_next_s = '0;
        end else begin
            arb_next_s = arb_idx_s + LANE_W'(1);
        end
    end

    // One-hot acknowledge and the winning lane's candidate word.
    always_comb begin
        arb_ack_s  = '0;
        arb_word_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (arb_hit_s && (arb_idx_s == LANE_W'(i))) begin
                arb_ack_s[i] = 1'b1;
                arb_word_s   = lane_word[i*WORD_W +: WORD_W];
            end else begin
                arb_ack_s[i] = 1'b0;
            end
        end
    end

    // Scheduler FSM; every output is a register written here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r           <= ST_IDLE;
            ptr_r             <= '0;
            target_r          <= '0;
            job_word_r        <= '0;
            job_lane_r        <= '0;
            lane_ack_r        <= '0;
            core_msg_valid_r  <= 1'b0;
            busy_r            <= 1'b0;
            found_r           <= 1'b0;
            found_lane_r      <= '0;
            found_plaintext_r <= '0;
            last_digest_r     <= '0;
            hash_count_r      <= '0;
`ifdef MD5_WDOG_EN
            wdog_cnt_r        <= '0;
            wdog_err_r        <= 1'b0;
`endif
        end else begin
            lane_ack_r       <= '0;
            core_msg_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        target_r          <= target_hash;
                        found_r           <= 1'b0;
                        found_lane_r      <= '0;
                        found_plaintext_r <= '0;
                        hash_count_r      <= '0;
                        last_digest_r     <= '0;
                        busy_r            <= 1'b1;
`ifdef MD5_WDOG_EN
                        wdog_err_r        <= 1'b0;
`endif
                        state_r           <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (arb_hit_s) begin
                        job_word_r <= arb_word_s;
                        job_lane_r <= arb_idx_s;
                        lane_ack_r <= arb_ack_s;
                        ptr_r      <= arb_next_s;
                        state_r    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (core_ready) begin
                        core_msg_valid_r <= 1'b1;
`ifdef MD5_WDOG_EN
                        wdog_cnt_r       <= '0;
`endif
                        state_r          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (core_out_valid) begin
                        last_digest_r <= core_digest;
                        state_r       <= ST_CHECK;
`ifdef MD5_WDOG_EN
                    end else if (wdog_cnt_r == WDOG_LAST) begin
                        // Core lost the job: flag it and resend the same word.
                        wdog_err_r <= 1'b1;
                        state_r    <= ST_ISSUE;
                    end else begin
                        wdog_cnt_r <= wdog_cnt_r + 32'd1;
`endif
                    end
                end
                ST_CHECK: begin
                    hash_count_r <= sat_inc(hash_count_r);
                    if (last_digest_r == target_r) begin
                        found_r           <= 1'b1;
                        found_lane_r      <= job_lane_r;
                        found_plaintext_r <= job_word_r;
                        busy_r            <= 1'b0;
                        state_r           <= ST_DONE;
                    end else begin
                        state_r           <= ST_ARB;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign lane_ack        = lane_ack_r;
    assign core_msg        = job_word_r;
    assign core_msg_width  = 8'(MSG_WIDTH);
    assign core_msg_valid  = core_msg_valid_r;
    assign busy            = busy_r;
    assign found           = found_r;
    assign found_lane      = found_lane_r;
    assign found_plaintext = found_plaintext_r;
    assign last_digest     = last_digest_r;
    assign hash_count      = hash_count_r;
`ifdef MD5_WDOG_EN
    assign wdog_err        = wdog_err_r;
`endif

endmodule

// File: tb/tb_md5_lane_scheduler.sv
// Scoreboard bench for md5_lane_scheduler.
// The stimulus pushes expected grants and issued words into queues.
// A monitor pops them and compares whenever lane_ack or core_msg_valid pulses.
// A small core model answers each issue with word ^ XC after 5 cycles.
module tb_md5_lane_scheduler;

    localparam int N = 4;
    localparam int W = 128;
    localparam logic [127:0] XC = 128'h0F0F_0F0F_3C3C_3C3C_A5A5_A5A5_0FF0_0FF0;

    logic               clock;
    logic               reset;
    logic               start;
    logic [127:0]       target_hash;
    logic [N-1:0]       lane_valid;
    logic [N*W-1:0]     lane_word;
    logic [N-1:0]       lane_ack;
    logic               core_ready;
    logic [W-1:0]       core_msg;
    logic [7:0]         core_msg_width;
    logic               core_msg_valid;
    logic               core_out_valid;
    logic [127:0]       core_digest;
    logic               busy;
    logic               found;
    logic [1:0]         found_lane;
    logic [W-1:0]       found_plaintext;
    logic [127:0]       last_digest;
    logic [31:0]        hash_count;
`ifdef MD5_WDOG_EN
    logic               wdog_err;
`endif

    int total = 0;
    int bad   = 0;
    int ack_q[$];
    logic [W-1:0] msg_q[$];
    logic [31:0] lane_cnt [N];
    logic drop_next = 1'b0;
    int resp_cnt = 0;

    md5_lane_scheduler #(
        .NUM_LANES(N),
        .WORD_W(W),
`ifdef MD5_WDOG_EN
        .MSG_WIDTH(128),
        .WDOG_CYCLES(8)
`else
        .MSG_WIDTH(128)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .target_hash(target_hash),
        .lane_valid(lane_valid),
        .lane_word(lane_word),
        .lane_ack(lane_ack),
        .core_ready(core_ready),
        .core_msg(core_msg),
        .core_msg_width(core_msg_width),
        .core_msg_valid(core_msg_valid),
        .core_out_valid(core_out_valid),
        .core_digest(core_digest),
        .busy(busy),
        .found(found),
        .found_lane(found_lane),
        .found_plaintext(found_plaintext),
        .last_digest(last_digest),
`ifdef MD5_WDOG_EN
        .hash_count(hash_count),
        .wdog_err(wdog_err)
`else
        .hash_count(hash_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Candidate n of lane l.
    function automatic logic [127:0] cand(input int lane, input logic [31:0] n);
        logic [7:0] l8;
        l8 = lane[7:0];
        return {16'hC0DE, l8, 8'h5A, 32'h1234_5678, 32'h9ABC_DEF0, n};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Lane generators present cand(lane, count).
    always_comb begin
        lane_word = '0;
        for (int i = 0; i < N; i++) begin
            lane_word[i*W +: W] = cand(i, lane_cnt[i]);
        end
    end

    // A lane advances to its next candidate when it is acknowledged.
    initial begin
        for (int i = 0; i < N; i++) lane_cnt[i] = 32'd0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                if (lane_ack[i] === 1'b1) lane_cnt[i] = lane_cnt[i] + 32'd1;
            end
        end
    end

    // Core model: digest = word ^ XC, five cycles after the issue strobe.
    initial begin
        logic [W-1:0] w;
        core_out_valid = 1'b0;
        core_digest    = '0;
        forever begin
            @(negedge clock);
            if (core_msg_valid === 1'b1) begin
                if (drop_next) begin
                    drop_next = 1'b0;
                end else begin
                    w = core_msg;
                    repeat (4) @(negedge clock);
                    core_digest    = w ^ XC;
                    core_out_valid = 1'b1;
                    resp_cnt       = resp_cnt + 1;
                    @(negedge clock);
                    core_out_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: pop and compare on every grant and every issue.
    initial begin
        int e;
        logic [W-1:0] m;
        forever begin
            @(negedge clock);
            if (lane_ack !== '0) begin
                if (ack_q.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL unexpected_ack: got %b expected none", lane_ack);
                end else begin
                    e = ack_q.pop_front();
                    check("ack_order", 128'(lane_ack), 128'(4'b0001 << e));
                end
            end
            if (core_msg_valid === 1'b1) begin
                if (msg_q.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL unexpected_issue: got %h expected none", core_msg);
                end else begin
                    m = msg_q.pop_front();
                    check("issue_word", core_msg, m);
                end
            end
        end
    end

    task automatic pulse_start(input logic [127:0] tgt);
        target_hash = tgt;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_found(input string name, input int max_cycles);
        int t;
        t = 0;
        while (found !== 1'b1 && t < max_cycles) begin
            @(negedge clock);
            t = t + 1;
        end
        check(name, 128'(found), 128'(1'b1));
    endtask

    task automatic wait_hash(input string name, input logic [31:0] n, input int max_cycles);
        int t;
        t = 0;
        while (hash_count !== n && t < max_cycles) begin
            @(negedge clock);
            t = t + 1;
        end
        check(name, 128'(hash_count), 128'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] c0, c1, c2, c3;
        logic [127:0] tgt;
        int t, n, pulses;

        reset = 1'b1; start = 1'b0; target_hash = '0;
        lane_valid = '0; core_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_found", 128'(found), 128'(1'b0));
        check("rst_found_lane", 128'(found_lane), 128'(2'd0));
        check("rst_plaintext", found_plaintext, 128'd0);
        check("rst_last_digest", last_digest, 128'd0);
        check("rst_hash_count", 128'(hash_count), 128'd0);
        check("rst_lane_ack", 128'(lane_ack), 128'd0);
        check("rst_msg_valid", 128'(core_msg_valid), 128'd0);
        check("rst_core_msg", core_msg, 128'd0);
        check("msg_width", 128'(core_msg_width), 128'd128);
`ifdef MD5_WDOG_EN
        check("rst_wdog_err", 128'(wdog_err), 128'd0);
`endif

        // Single lane: only lane 2, match on its third word
        lane_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            ack_q.push_back(2);
            msg_q.push_back(cand(2, 32'(k)));
        end
        pulse_start(cand(2, 32'd2) ^ XC);
        wait_found("t1_found", 200);
        check("t1_found_lane", 128'(found_lane), 128'(2'd2));
        check("t1_plaintext", found_plaintext, cand(2, 32'd2));
        check("t1_hash_count", 128'(hash_count), 128'd3);
        check("t1_busy", 128'(busy), 128'(1'b0));
        check("t1_last_digest", last_digest, cand(2, 32'd2) ^ XC);
        lane_valid = '0;

        // All lanes valid, no match: strict 0,1,2,3 order from pointer 0
        do_reset();
        check("t2_found_after_reset", 128'(found), 128'(1'b0));
        lane_valid = 4'b1111;
        for (int r = 0; r < 3; r++) begin
            for (int l = 0; l < N; l++) begin
                ack_q.push_back(l);
                msg_q.push_back(cand(l, lane_cnt[l] + 32'(r)));
            end
        end
        target_hash = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
        pulse_start(128'h5555_5555_5555_5555_5555_5555_5555_5555);
        t = 0;
        while (hash_count !== 32'd12 && t < 400) begin
            @(negedge clock);
            t = t + 1;
        end
        lane_valid = '0;
        check("t2_hash_count", 128'(hash_count), 128'd12);
        check("t2_acks_consumed", 128'(ack_q.size()), 128'd0);
        check("t2_found", 128'(found), 128'(1'b0));
        check("t2_busy", 128'(busy), 128'(1'b1));

        // core_ready low for 10 cycles while in ISSUE
        core_ready = 1'b0;
        c0 = lane_cnt[0];
        ack_q.push_back(0);
        msg_q.push_back(cand(0, c0));
        lane_valid = 4'b0001;
        t = 0;
        while (lane_ack === '0 && t < 20) begin
            @(negedge clock);
            t = t + 1;
        end
        lane_valid = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check("t3_no_issue", 128'(core_msg_valid), 128'(1'b0));
            check("t3_msg_stable", core_msg, cand(0, c0));
        end
        core_ready = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (core_msg_valid === 1'b1) pulses = pulses + 1;
        end
        check("t3_one_pulse", 128'(pulses), 128'd1);
        wait_hash("t3_hash_count", 32'd13, 50);

        // Reset while in WAIT, then a stale core_out_valid
        c1 = lane_cnt[1];
        ack_q.push_back(1);
        msg_q.push_back(cand(1, c1));
        lane_valid = 4'b0010;
        t = 0;
        while (core_msg_valid !== 1'b1 && t < 30) begin
            @(negedge clock);
            t = t + 1;
        end
        n = resp_cnt;
        reset = 1'b1;
        lane_valid = '0;
        @(negedge clock);
        check("t4_rst_busy", 128'(busy), 128'(1'b0));
        check("t4_rst_hash", 128'(hash_count), 128'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("t4_stale_seen", 128'(resp_cnt), 128'(n + 1));
        check("t4_busy", 128'(busy), 128'(1'b0));
        check("t4_found", 128'(found), 128'(1'b0));
        check("t4_hash", 128'(hash_count), 128'd0);
        check("t4_last_digest", last_digest, 128'd0);
        check("t4_msg", core_msg, 128'd0);

        // Match, then restart with a new target from the stored pointer
        c0 = lane_cnt[0];
        c1 = lane_cnt[1];
        ack_q.push_back(0); msg_q.push_back(cand(0, c0));
        ack_q.push_back(1); msg_q.push_back(cand(1, c1));
        lane_valid = 4'b1111;
        pulse_start(cand(1, c1) ^ XC);
        wait_found("t5_found", 200);
        check("t5_found_lane", 128'(found_lane), 128'(2'd1));
        check("t5_plaintext", found_plaintext, cand(1, c1));
        check("t5_hash", 128'(hash_count), 128'd2);
        c2 = lane_cnt[2];
        c3 = lane_cnt[3];
        ack_q.push_back(2); msg_q.push_back(cand(2, c2));
        ack_q.push_back(3); msg_q.push_back(cand(3, c3));
        tgt = cand(3, c3) ^ XC;
        pulse_start(tgt);
        check("t5_found_cleared", 128'(found), 128'(1'b0));
        check("t5_hash_cleared", 128'(hash_count), 128'd0);
        check("t5_busy_restart", 128'(busy), 128'(1'b1));
        wait_found("t5_found2", 200);
        check("t5_found_lane2", 128'(found_lane), 128'(2'd3));
        check("t5_plaintext2", found_plaintext, cand(3, c3));
        check("t5_hash2", 128'(hash_count), 128'd2);
        lane_valid = '0;

`ifdef MD5_WDOG_EN
        // Watchdog: first issue is never answered
        c0 = lane_cnt[0];
        ack_q.push_back(0);
        msg_q.push_back(cand(0, c0));
        msg_q.push_back(cand(0, c0));
        drop_next = 1'b1;
        lane_valid = 4'b0001;
        pulse_start(cand(0, c0) ^ XC);
        t = 0;
        while (core_msg_valid !== 1'b1 && t < 30) begin
            @(negedge clock);
            t = t + 1;
        end
        lane_valid = '0;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            n = k;
            if (wdog_err === 1'b1) break;
        end
        check("t6_wdog_delay", 128'(n), 128'd8);
        check("t6_hash_unchanged", 128'(hash_count), 128'd0);
        wait_found("t6_found", 100);
        check("t6_wdog_err", 128'(wdog_err), 128'(1'b1));
        check("t6_hash", 128'(hash_count), 128'd1);
        check("t6_plaintext", found_plaintext, cand(0, c0));
`endif

        repeat (3) @(negedge clock);
        check("ack_q_empty", 128'(ack_q.size()), 128'd0);
        check("msg_q_empty", 128'(msg_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
